line_trigger_sequencer: RTL and testbench

Schedules line acquisitions for the linear image sensor and frames the ADC pixel stream. Triggers come either from the quadrature encoder step pulse, divided by a programmable ratio, or from a free-running period timer. The block issues the sensor SI pulse, enforces a minimum line period, and marks the DUMMY_CNT lead-in and PIX_CNT active pixels of each line for the capture path. It sits between the encoder decoder/register file and the sensor/ADC capture logic in `top`.

---
 rtl/line_trigger_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_line_trigger_sequencer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_trigger_sequencer.sv
// line_trigger_sequencer
//   Schedules line acquisitions for the linear image sensor and frames the
//   ADC pixel stream. Triggers come from the encoder step pulse (divided by
//   i_enc_div) or from a free-running period timer. Each line issues the SI
//   pulse, marks DUMMY_CNT lead-in clocks and PIX_CNT active pixels, and
//   enforces MIN_PERIOD clocks between consecutive SI rises.
//
// Ports
//   i_clk          sensor clock (same net as CLKC)
//   i_rst          synchronous, active-high reset
//   i_enable       accept triggers
//   i_mode         trigger source: 0 = free-run timer, 1 = encoder
//   i_free_period  free-run period in clocks, 0 disables the timer
//   i_enc_div      encoder steps per trigger, 0 behaves as 1
//   i_enc_step     one-clock pulse per decoded encoder step
//   o_si           sensor start-integration pulse
//   o_pix_valid    current ADC sample is an active pixel
//   o_pix_idx      active pixel index, 0 outside active pixels
//   o_line_start   pulse on the first active pixel
//   o_line_end     pulse on the last active pixel
//   o_line_cnt     completed lines, wrapping
//   o_trig_miss    pulse one clock after a dropped trigger
//   o_busy         high whenever a line is in progress
//   o_miss_cnt     saturating dropped-trigger count
//
// Build option
//   LINESEQ_MISS_CNT_EN : builds the dropped-trigger counter; when undefined
//                         o_miss_cnt is tied to 0.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | waiting for a trigger or the pending flag
// S_EXPOSE | SI pulse, then lead-in clocks up to the first valid pixel
// S_ACTIVE | PIX_CNT active pixels
// S_GUARD  | hold-off until MIN_PERIOD clocks after the SI rise

module line_trigger_sequencer #(
   parameter int DUMMY_CNT  = 89,
   parameter int PIX_CNT    = 2592,
   parameter int SI_WIDTH   = 2,
   parameter int MIN_PERIOD = 2800
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_enable,
   input  logic        i_mode,
   input  logic [15:0] i_free_period,
   input  logic [7:0]  i_enc_div,
   input  logic        i_enc_step,
   output logic        o_si,
   output logic        o_pix_valid,
   output logic [11:0] o_pix_idx,
   output logic        o_line_start,
   output logic        o_line_end,
   output logic [15:0] o_line_cnt,
   output logic        o_trig_miss,
   output logic        o_busy,
   output logic [15:0] o_miss_cnt
);

   typedef enum logic [1:0] {S_IDLE, S_EXPOSE, S_ACTIVE, S_GUARD} state_t;

   localparam logic [15:0] C_EXP_LAST   = 16'(DUMMY_CNT - 1);
   // Leaving GUARD at this count puts the launch in the IDLE cycle just
   // before MIN_PERIOD, so the next SI rises exactly MIN_PERIOD after this one.
   localparam logic [15:0] C_GUARD_LAST = 16'(MIN_PERIOD - 2);
   localparam logic [15:0] C_SI_W       = 16'(SI_WIDTH);
   localparam logic [11:0] C_PIX_LAST   = 12'(PIX_CNT - 1);

   state_t      r_state, w_state_nxt;
   logic        r_mode_q, r_pend;
   logic [7:0]  r_enc_cnt;
   logic [15:0] r_tmr_cnt, r_per_cnt;
   logic        r_si, r_pix_valid, r_line_start, r_line_end, r_trig_miss, r_busy;
   logic [11:0] r_pix_idx;
   logic [15:0] r_line_cnt;

   logic        w_mode_chg, w_enc_run, w_tmr_run, w_trig_enc, w_trig_tmr;
   logic        w_trig, w_launch, w_miss;
   logic [8:0]  w_div_eff, w_enc_inc;
   logic [16:0] w_tmr_inc;
   logic [15:0] w_per_nxt;
   logic [11:0] w_pix_nxt;
   logic        w_si_nxt, w_pv_nxt, w_ls_nxt, w_le_nxt, w_busy_nxt;

   // Trigger sources. A mode change swallows that cycle's trigger and
   // restarts both dividers from zero.
   always_comb begin
      w_mode_chg = (i_mode != r_mode_q);
      w_div_eff  = (i_enc_div == 8'd0) ? 9'd1 : {1'b0, i_enc_div};
      w_enc_inc  = {1'b0, r_enc_cnt} + 9'd1;
      w_tmr_inc  = {1'b0, r_tmr_cnt} + 17'd1;
      w_enc_run  = i_enable && i_mode && i_enc_step && !w_mode_chg;
      w_tmr_run  = i_enable && !i_mode && (i_free_period != 16'd0) && !w_mode_chg;
      w_trig_enc = w_enc_run && (w_enc_inc >= w_div_eff);
      w_trig_tmr = w_tmr_run && (w_tmr_inc >= {1'b0, i_free_period});
      w_trig     = w_trig_enc || w_trig_tmr;
      w_launch   = (r_state == S_IDLE) && i_enable && (w_trig || r_pend);
      w_miss     = (r_state != S_IDLE) && w_trig && r_pend;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_mode_q  <= 1'b0;
         r_enc_cnt <= 8'd0;
         r_tmr_cnt <= 16'd0;
         r_pend    <= 1'b0;
      end else begin
         r_mode_q <= i_mode;
         if (w_mode_chg) begin
            r_enc_cnt <= 8'd0;
            r_tmr_cnt <= 16'd0;
         end else begin
            if (w_enc_run) r_enc_cnt <= w_trig_enc ? 8'd0 : w_enc_inc[7:0];
            if (w_tmr_run) r_tmr_cnt <= w_trig_tmr ? 16'd0 : w_tmr_inc[15:0];
         end
         // In IDLE the flag is consumed by the launch; disabled it is dropped.
         if (!i_enable || r_state == S_IDLE) r_pend <= 1'b0;
         else if (w_trig)                    r_pend <= 1'b1;
      end
   end

   // State register
   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next state
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (w_launch) w_state_nxt = S_EXPOSE;
         S_EXPOSE: if (r_per_cnt >= C_EXP_LAST) w_state_nxt = S_ACTIVE;
         S_ACTIVE: if (r_pix_idx == C_PIX_LAST)
                      w_state_nxt = (r_per_cnt >= C_GUARD_LAST) ? S_IDLE : S_GUARD;
         S_GUARD:  if (r_per_cnt >= C_GUARD_LAST) w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // Outputs are computed one cycle ahead from the next state and registered.
   always_comb begin
      w_per_nxt  = (r_state == S_IDLE) ? 16'd0 : r_per_cnt + 16'd1;
      w_pv_nxt   = (w_state_nxt == S_ACTIVE);
      w_pix_nxt  = 12'd0;
      if (w_pv_nxt && r_state == S_ACTIVE) w_pix_nxt = r_pix_idx + 12'd1;
      w_si_nxt   = (w_state_nxt == S_EXPOSE) && (w_per_nxt < C_SI_W);
      w_ls_nxt   = w_pv_nxt && (r_state != S_ACTIVE);
      w_le_nxt   = w_pv_nxt && (w_pix_nxt == C_PIX_LAST);
      w_busy_nxt = (w_state_nxt != S_IDLE);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_per_cnt    <= 16'd0;
         r_si         <= 1'b0;
         r_pix_valid  <= 1'b0;
         r_pix_idx    <= 12'd0;
         r_line_start <= 1'b0;
         r_line_end   <= 1'b0;
         r_line_cnt   <= 16'd0;
         r_trig_miss  <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_per_cnt    <= w_per_nxt;
         r_si         <= w_si_nxt;
         r_pix_valid  <= w_pv_nxt;
         r_pix_idx    <= w_pix_nxt;
         r_line_start <= w_ls_nxt;
         r_line_end   <= w_le_nxt;
         r_trig_miss  <= w_miss;
         r_busy       <= w_busy_nxt;
         if (w_le_nxt) r_line_cnt <= r_line_cnt + 16'd1;
      end
   end

`ifdef LINESEQ_MISS_CNT_EN
   logic [15:0] r_miss_cnt;
   always_ff @(posedge i_clk) begin
      if (i_rst)                                r_miss_cnt <= 16'd0;
      else if (w_miss && r_miss_cnt != 16'hFFFF) r_miss_cnt <= r_miss_cnt + 16'd1;
   end
   assign o_miss_cnt = r_miss_cnt;
`else
   assign o_miss_cnt = 16'd0;
`endif

   assign o_si         = r_si;
   assign o_pix_valid  = r_pix_valid;
   assign o_pix_idx    = r_pix_idx;
   assign o_line_start = r_line_start;
   assign o_line_end   = r_line_end;
   assign o_line_cnt   = r_line_cnt;
   assign o_trig_miss  = r_trig_miss;
   assign o_busy       = r_busy;

endmodule

// File: tb/tb_line_trigger_sequencer.sv
// Bench for line_trigger_sequencer: a cycle model built on the SI rise time of
// the current line (every output is an arithmetic function of clocks since
// that rise) is compared with the DUT every cycle, plus literal checks of the
// scheduled timing for each scenario.
module tb_line_trigger_sequencer;
   localparam int D = 89, P = 2592, SW = 2, MP = 2800;
`ifdef LINESEQ_MISS_CNT_EN
   localparam bit MISS_EN = 1'b1;
`else
   localparam bit MISS_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst, en, mode, step;
   logic [15:0] fp;
   logic [7:0]  div;
   logic        si, pv, ls, le, tm, busy;
   logic [11:0] idx;
   logic [15:0] lc, mc;

   line_trigger_sequencer dut (
      .i_clk(clk), .i_rst(rst), .i_enable(en), .i_mode(mode),
      .i_free_period(fp), .i_enc_div(div), .i_enc_step(step),
      .o_si(si), .o_pix_valid(pv), .o_pix_idx(idx), .o_line_start(ls),
      .o_line_end(le), .o_line_cnt(lc), .o_trig_miss(tm), .o_busy(busy),
      .o_miss_cnt(mc)
   );

   always #5 clk = ~clk;

   int total = 0, bad = 0;
   int tb_cyc = 0;
   bit chk_en = 1'b0;

   // model state
   bit m_has, m_pend, m_last_mode;
   int m_s, m_enc, m_tmr, m_lc, m_mc;
   // expected outputs for the cycle after the next edge
   logic        e_si, e_pv, e_ls, e_le, e_tm, e_busy;
   logic [11:0] e_idx;
   logic [15:0] e_lc, e_mc;

   // monitor
   int rises[$];
   bit prev_si = 1'b0;
   int last_rise = 0, ls_off = -1, le_off = -1, le_idx = -1, le_cnt = 0;
   int first_le_lc = -1, miss_pulses = 0;

   task automatic chk(input string name, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", name, got, exp);
      end
   endtask

   // Uses the inputs applied for cycle tb_cyc; produces expectations for tb_cyc+1.
   task automatic model_update();
      int c, k, dv;
      bit trig, miss, idle;
      c = tb_cyc; trig = 0; miss = 0;
      if (rst) begin
         m_has = 0; m_pend = 0; m_enc = 0; m_tmr = 0; m_last_mode = 0;
         m_lc = 0; m_mc = 0;
      end else begin
         if (mode != m_last_mode) begin
            m_enc = 0; m_tmr = 0;
         end else if (en) begin
            if (mode && step) begin
               dv = (div == 0) ? 1 : int'(div);
               if (m_enc + 1 >= dv) begin trig = 1; m_enc = 0; end
               else m_enc++;
            end
            if (!mode && fp != 0) begin
               if (m_tmr + 1 >= int'(fp)) begin trig = 1; m_tmr = 0; end
               else m_tmr++;
            end
         end
         m_last_mode = mode;
         idle = !m_has || (c - m_s >= MP - 1);
         if (!en) m_pend = 0;
         else if (idle) begin
            if (trig || m_pend) begin m_has = 1; m_s = c + 1; end
            m_pend = 0;
         end else if (trig) begin
            if (m_pend) miss = 1; else m_pend = 1;
         end
         if (miss && MISS_EN && m_mc != 65535) m_mc++;
         if (m_has && (c + 1 - m_s) == D + P - 1) m_lc = (m_lc + 1) % 65536;
      end
      k      = c + 1 - m_s;
      e_si   = m_has && k >= 0 && k < SW;
      e_pv   = m_has && k >= D && k < D + P;
      e_idx  = e_pv ? 12'(k - D) : 12'd0;
      e_ls   = e_pv && k == D;
      e_le   = e_pv && k == D + P - 1;
      e_busy = m_has && k >= 0 && k < MP - 1;
      e_tm   = miss;
      e_lc   = 16'(m_lc);
      e_mc   = 16'(m_mc);
   endtask

   always @(posedge clk) begin
      #1;
      tb_cyc++;
      if (chk_en) begin
         total++;
         if ({si, pv, idx, ls, le, lc, tm, busy, mc} !==
             {e_si, e_pv, e_idx, e_ls, e_le, e_lc, e_tm, e_busy, e_mc}) begin
            bad++;
            $display("FAIL outputs cyc=%0d got si=%b pv=%b idx=%0d ls=%b le=%b lc=%0d miss=%b busy=%b mc=%0d want si=%b pv=%b idx=%0d ls=%b le=%b lc=%0d miss=%b busy=%b mc=%0d",
                     tb_cyc, si, pv, idx, ls, le, lc, tm, busy, mc,
                     e_si, e_pv, e_idx, e_ls, e_le, e_lc, e_tm, e_busy, e_mc);
         end
      end
      if (si === 1'b1 && !prev_si) begin rises.push_back(tb_cyc); last_rise = tb_cyc; end
      prev_si = (si === 1'b1);
      if (ls === 1'b1) ls_off = tb_cyc - last_rise;
      if (le === 1'b1) begin
         le_off = tb_cyc - last_rise; le_idx = int'(idx);
         if (le_cnt == 0) first_le_lc = int'(lc);
         le_cnt++;
      end
      if (tm === 1'b1) miss_pulses++;
   end

   task automatic cyc_step();
      model_update();
      @(negedge clk);
   endtask

   task automatic run(input int n);
      repeat (n) cyc_step();
   endtask

   task automatic pulse_step();
      step = 1'b1; cyc_step(); step = 1'b0;
   endtask

   initial begin
      int n0, base, sc, le0, r0;
      rst = 1'b1; en = 1'b1; mode = 1'b0; fp = 16'd3000; div = 8'd0; step = 1'b0;
      model_update();
      chk_en = 1'b1;
      @(negedge clk);
      run(2);

      // free-run basic
      rst = 1'b0; n0 = tb_cyc;
      run(9200);
      chk("fr_rises", rises.size(), 3);
      if (rises.size() >= 3) begin
         chk("fr_first_rise", rises[0] - n0, 3000);
         chk("fr_spacing1", rises[1] - rises[0], 3000);
         chk("fr_spacing2", rises[2] - rises[1], 3000);
      end
      chk("fr_ls_offset", ls_off, 89);
      chk("fr_le_offset", le_off, 2680);
      chk("fr_le_idx", le_idx, 2591);
      chk("fr_first_lc", first_le_lc, 1);
      fp = 16'd0;
      run(3000);

      // encoder divide by 4, steps 800 apart
      mode = 1'b1; div = 8'd4;
      run(5);
      base = rises.size(); sc = 0;
      for (int i = 0; i < 4; i++) begin
         run(799);
         sc = tb_cyc;
         pulse_step();
      end
      run(5);
      chk("enc4_rises", rises.size() - base, 1);
      chk("enc4_rise_time", rises[$] - sc, 1);
      run(3000);

      // ENC_DIV=0 behaves as 1
      div = 8'd0; base = rises.size();
      for (int i = 0; i < 3; i++) begin
         pulse_step();
         run(2900);
      end
      chk("enc0_rises", rises.size() - base, 3);

      // over-rate: one step per 1000 clocks
      div = 8'd1;
      run(100);
      base = rises.size();
      for (int i = 0; i < 9; i++) begin
         pulse_step();
         run(999);
      end
      run(3000);
      chk("or_rises", rises.size() - base, 4);
      if (rises.size() - base >= 4)
         for (int i = 1; i < 4; i++)
            chk("or_spacing", rises[base + i] - rises[base + i - 1], 2800);
      chk("or_miss_pulses", miss_pulses, 5);
      chk("or_miss_cnt", int'(mc), MISS_EN ? 5 : 0);

      // ENABLE drop with a trigger pending
      pulse_step();
      run(99);
      pulse_step();
      run(989);
      chk("en_drop_idx", int'(idx), 1000);
      en = 1'b0; le0 = le_cnt; r0 = rises.size();
      run(4500);
      chk("en_drop_le", le_cnt - le0, 1);
      chk("en_drop_no_si", rises.size(), r0);
      en = 1'b1;
      run(20);
      chk("en_drop_pend_gone", rises.size(), r0);

      // reset mid-line at PIX_IDX=500
      pulse_step();
      run(589);
      chk("rst_idx", int'(idx), 500);
      rst = 1'b1; cyc_step(); rst = 1'b0;
      chk("rst_busy", int'(busy), 0);
      chk("rst_lc", int'(lc), 0);
      chk("rst_pv", int'(pv), 0);
      run(10);
      sc = tb_cyc;
      pulse_step();
      run(5);
      chk("rst_restart", rises[$] - sc, 1);
      run(3000);

      // LINE_CNT wrap
      force dut.r_line_cnt = 16'hFFFF;
      m_lc = 65535;
      cyc_step();
      release dut.r_line_cnt;
      run(2);
      le0 = le_cnt;
      pulse_step();
      run(2800);
      chk("wrap_le", le_cnt - le0, 1);
      chk("wrap_lc", int'(lc), 0);

`ifdef LINESEQ_MISS_CNT_EN
      force dut.r_miss_cnt = 16'hFFFF;
      m_mc = 65535;
      cyc_step();
      release dut.r_miss_cnt;
      pulse_step(); run(10);
      pulse_step(); run(10);
      pulse_step(); run(5);
      chk("sat_pulses", miss_pulses, 6);
      chk("sat_mc", int'(mc), 65535);
      run(2800);
`endif

      // randomized soak
      for (int i = 0; i < 8000; i++) begin
         if ($urandom_range(0, 399) == 0) begin
            mode = ~mode;
            fp = ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom_range(1500, 3600));
            div = 8'($urandom_range(0, 3));
         end
         if ($urandom_range(0, 1499) == 0) en = ~en;
         step = ($urandom_range(0, 199) == 0);
         cyc_step();
      end
      step = 1'b0;
      run(5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
